// File: rtl/stx_core_if.sv
// stx_core_if: store-aligner bus bundle.
//   master: drives din/byte_offset/st_sel and receives dout/wbe/misaligned.
//   slave : the aligner side.
// Also provides the default st_sel encoding (ST_BYTE/ST_HALF/ST_WORD, with
// 2'b11 meaning no store) when control_signals.vh has not already defined it.
`ifndef ST_BYTE
`define ST_BYTE 2'b00
`endif
`ifndef ST_HALF
`define ST_HALF 2'b01
`endif
`ifndef ST_WORD
`define ST_WORD 2'b10
`endif

interface stx_core_if;
    logic [31:0] din;
    logic [1:0]  byte_offset;
    logic [1:0]  st_sel;
    logic [31:0] dout;
    logic [3:0]  wbe;
    logic        misaligned;

    modport master (
        output din, byte_offset, st_sel,
        input  dout, wbe, misaligned
    );

    modport slave (
        input  din, byte_offset, st_sel,
        output dout, wbe, misaligned
    );
endinterface

// File: rtl/stx_core.sv
// stx_core: store-data aligner for the memory stage.
// Shifts rs2 into its byte lanes, builds the 4-bit write enable and flags
// misaligned half/word stores (write suppressed).
// Ports:
//   clk, rst_n  - clock / async active-low reset (output register build only)
//   bus (slave) - din[31:0], byte_offset[1:0], st_sel[1:0] in;
//                 dout[31:0], wbe[3:0], misaligned out
// Build option: define STX_OUTPUT_REG_EN to register all outputs (1 cycle
// latency, async reset to zero). Default build is purely combinational.
`ifndef ST_BYTE
`define ST_BYTE 2'b00
`endif
`ifndef ST_HALF
`define ST_HALF 2'b01
`endif
`ifndef ST_WORD
`define ST_WORD 2'b10
`endif

module stx_core (
    input  logic    clk,
    input  logic    rst_n,
    stx_core_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = 4;

    logic [DATA_W-1:0] w_dout;
    logic [LANES-1:0]  w_wbe;
    logic              w_misaligned;

    // Lane shift applies to every st_sel; only wbe depends on width legality.
    always_comb begin
        w_dout       = bus.din << {bus.byte_offset, 3'b000};
        w_wbe        = '0;
        w_misaligned = 1'b0;
        case (bus.st_sel)
            `ST_BYTE: w_wbe = LANES'(4'b0001) << bus.byte_offset;
            `ST_HALF: begin
                if (bus.byte_offset[0]) begin
                    w_misaligned = 1'b1;
                end else begin
                    w_wbe = bus.byte_offset[1] ? LANES'(4'b1100) : LANES'(4'b0011);
                end
            end
            `ST_WORD: begin
                if (bus.byte_offset != 2'd0) begin
                    w_misaligned = 1'b1;
                end else begin
                    w_wbe = LANES'(4'b1111);
                end
            end
            default: ;  // no-store code: nothing enabled, not misaligned
        endcase
    end

`ifdef STX_OUTPUT_REG_EN
    logic [DATA_W-1:0] r_dout;
    logic [LANES-1:0]  r_wbe;
    logic              r_misaligned;

    // Output pipeline stage; reset discards any in-flight value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout       <= '0;
            r_wbe        <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_dout       <= w_dout;
            r_wbe        <= w_wbe;
            r_misaligned <= w_misaligned;
        end
    end

    assign bus.dout       = r_dout;
    assign bus.wbe        = r_wbe;
    assign bus.misaligned = r_misaligned;
`else
    // Clock and reset are only needed by the registered build.
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst_n;

    assign bus.dout       = w_dout;
    assign bus.wbe        = w_wbe;
    assign bus.misaligned = w_misaligned;
`endif

endmodule

// File: tb/tb_stx_core.sv
// tb_stx_core: directed self-checking bench for stx_core (either build).
`ifndef ST_BYTE
`define ST_BYTE 2'b00
`endif
`ifndef ST_HALF
`define ST_HALF 2'b01
`endif
`ifndef ST_WORD
`define ST_WORD 2'b10
`endif

module tb_stx_core;
    localparam logic [1:0] ST_NONE = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    stx_core_if bus ();

    stx_core u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Drive inputs and wait until the outputs reflect them.
    task automatic apply(input logic [31:0] d, input logic [1:0] sel, input logic [1:0] off);
        bus.din         = d;
        bus.st_sel      = sel;
        bus.byte_offset = off;
`ifdef STX_OUTPUT_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    task automatic test_reset();
`ifdef STX_OUTPUT_REG_EN
        bus.din = 32'h12345678; bus.st_sel = `ST_WORD; bus.byte_offset = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.dout !== 32'h0 || bus.wbe !== 4'b0000 || bus.misaligned !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: got dout=%h wbe=%b mis=%b, want 0/0000/0", bus.dout, bus.wbe, bus.misaligned);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.dout !== 32'h0 || bus.wbe !== 4'b0000) begin
            failures++;
            $display("FAIL release_no_edge: got dout=%h wbe=%b, want 0/0000", bus.dout, bus.wbe);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.dout !== 32'h12345678 || bus.wbe !== 4'b1111 || bus.misaligned !== 1'b0) begin
            failures++;
            $display("FAIL first_edge: got dout=%h wbe=%b mis=%b, want 12345678/1111/0", bus.dout, bus.wbe, bus.misaligned);
        end
        // Mid-cycle async reset clears immediately.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.dout !== 32'h0 || bus.wbe !== 4'b0000 || bus.misaligned !== 1'b0) begin
            failures++;
            $display("FAIL async_clear: got dout=%h wbe=%b mis=%b, want 0/0000/0", bus.dout, bus.wbe, bus.misaligned);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.st_sel = `ST_BYTE; bus.byte_offset = 2'd3;
        #1;
        checks++;
        if (bus.dout !== 32'h0 || bus.wbe !== 4'b0000) begin
            failures++;
            $display("FAIL pre_edge: got dout=%h wbe=%b, want 0/0000", bus.dout, bus.wbe);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.dout !== 32'h78000000 || bus.wbe !== 4'b1000 || bus.misaligned !== 1'b0) begin
            failures++;
            $display("FAIL byte3_after_reset: got dout=%h wbe=%b mis=%b, want 78000000/1000/0", bus.dout, bus.wbe, bus.misaligned);
        end
`else
        // Combinational build ignores reset entirely.
        apply(32'h12345678, `ST_WORD, 2'd0);
        checks++;
        if (bus.dout !== 32'h12345678 || bus.wbe !== 4'b1111 || bus.misaligned !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_effect: got dout=%h wbe=%b mis=%b, want 12345678/1111/0", bus.dout, bus.wbe, bus.misaligned);
        end
        rst_n = 1'b1;
`endif
    endtask

    task automatic test_word();
        apply(32'h12345678, `ST_WORD, 2'd0);
        checks++;
        if (bus.dout !== 32'h12345678 || bus.wbe !== 4'b1111 || bus.misaligned !== 1'b0) begin
            failures++;
            $display("FAIL word_off0: got dout=%h wbe=%b mis=%b, want 12345678/1111/0", bus.dout, bus.wbe, bus.misaligned);
        end
    endtask

    task automatic test_half();
        logic [31:0] exp_d [2];
        logic [3:0]  exp_w [2];
        logic [1:0]  offs  [2];
        exp_d = '{32'h12345678, 32'h56780000};
        exp_w = '{4'b0011, 4'b1100};
        offs  = '{2'd0, 2'd2};
        for (int i = 0; i < 2; i++) begin
            apply(32'h12345678, `ST_HALF, offs[i]);
            checks++;
            if (bus.dout !== exp_d[i] || bus.wbe !== exp_w[i] || bus.misaligned !== 1'b0) begin
                failures++;
                $display("FAIL half_off%0d: got dout=%h wbe=%b mis=%b, want %h/%b/0", offs[i], bus.dout, bus.wbe, bus.misaligned, exp_d[i], exp_w[i]);
            end
        end
        apply(32'hA5C3F00F, `ST_HALF, 2'd2);
        checks++;
        if (bus.dout !== 32'hF00F0000 || bus.wbe !== 4'b1100 || bus.misaligned !== 1'b0) begin
            failures++;
            $display("FAIL half_alt_off2: got dout=%h wbe=%b mis=%b, want f00f0000/1100/0", bus.dout, bus.wbe, bus.misaligned);
        end
    endtask

    task automatic test_byte();
        logic [31:0] exp_d [4];
        logic [3:0]  exp_w [4];
        exp_d = '{32'h12345678, 32'h34567800, 32'h56780000, 32'h78000000};
        exp_w = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            apply(32'h12345678, `ST_BYTE, 2'(i));
            checks++;
            if (bus.dout !== exp_d[i] || bus.wbe !== exp_w[i] || bus.misaligned !== 1'b0) begin
                failures++;
                $display("FAIL byte_off%0d: got dout=%h wbe=%b mis=%b, want %h/%b/0", i, bus.dout, bus.wbe, bus.misaligned, exp_d[i], exp_w[i]);
            end
        end
        apply(32'hA5C3F00F, `ST_BYTE, 2'd1);
        checks++;
        if (bus.dout !== 32'hC3F00F00 || bus.wbe !== 4'b0010) begin
            failures++;
            $display("FAIL byte_alt_off1: got dout=%h wbe=%b, want c3f00f00/0010", bus.dout, bus.wbe);
        end
    endtask

    task automatic test_misaligned();
        logic [1:0]  sels  [5];
        logic [1:0]  offs  [5];
        logic [31:0] exp_d [5];
        sels  = '{`ST_WORD, `ST_WORD, `ST_WORD, `ST_HALF, `ST_HALF};
        offs  = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd3};
        exp_d = '{32'h34567800, 32'h56780000, 32'h78000000, 32'h34567800, 32'h78000000};
        for (int i = 0; i < 5; i++) begin
            apply(32'h12345678, sels[i], offs[i]);
            checks++;
            if (bus.dout !== exp_d[i] || bus.wbe !== 4'b0000 || bus.misaligned !== 1'b1) begin
                failures++;
                $display("FAIL misaligned_%0d: got dout=%h wbe=%b mis=%b, want %h/0000/1", i, bus.dout, bus.wbe, bus.misaligned, exp_d[i]);
            end
        end
    endtask

    task automatic test_nostore();
        logic [31:0] exp_d [4];
        exp_d = '{32'h12345678, 32'h34567800, 32'h56780000, 32'h78000000};
        for (int i = 0; i < 4; i++) begin
            apply(32'h12345678, ST_NONE, 2'(i));
            checks++;
            if (bus.dout !== exp_d[i] || bus.wbe !== 4'b0000 || bus.misaligned !== 1'b0) begin
                failures++;
                $display("FAIL nostore_off%0d: got dout=%h wbe=%b mis=%b, want %h/0000/0", i, bus.dout, bus.wbe, bus.misaligned, exp_d[i]);
            end
        end
    endtask

    // Inputs change every cycle; outputs must follow with no bubbles.
    task automatic test_back_to_back();
        logic [31:0] exp_d [4];
        logic [3:0]  exp_w [4];
        exp_d = '{32'h000000EF, 32'h0000EF00, 32'h00EF0000, 32'hEF000000};
        exp_w = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            bus.din = 32'h000000EF; bus.st_sel = `ST_BYTE; bus.byte_offset = 2'(i);
`ifdef STX_OUTPUT_REG_EN
            #1;
            if (i > 0) begin
                checks++;
                if (bus.dout !== exp_d[i-1] || bus.wbe !== exp_w[i-1]) begin
                    failures++;
                    $display("FAIL b2b_latency_%0d: got dout=%h wbe=%b, want %h/%b", i, bus.dout, bus.wbe, exp_d[i-1], exp_w[i-1]);
                end
            end
            @(posedge clk);
`endif
            #1;
            checks++;
            if (bus.dout !== exp_d[i] || bus.wbe !== exp_w[i] || bus.misaligned !== 1'b0) begin
                failures++;
                $display("FAIL b2b_%0d: got dout=%h wbe=%b mis=%b, want %h/%b/0", i, bus.dout, bus.wbe, bus.misaligned, exp_d[i], exp_w[i]);
            end
        end
    endtask

    initial begin
        bus.din = '0;
        bus.st_sel = ST_NONE;
        bus.byte_offset = '0;
        #2;
        test_reset();
        test_word();
        test_half();
        test_byte();
        test_misaligned();
        test_nostore();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
